// File: rtl/ul_rdctrl_pkg.sv
// Shared types and helpers for the multi-bank uplink/downlink RAM readers.
package ul_rdctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } rd_fsm_e;

  localparam int BANK_W = 3;

  function automatic int unsigned bank_base(
    input int unsigned b,
    input int unsigned stride
  );
    return b * stride;
  endfunction

endpackage

// File: rtl/ul_rr_arbiter.sv
// Round-robin first-eligible picker: scans ptr, ptr+1, ... modulo N.
module ul_rr_arbiter
  import ul_rdctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      req,
  input  logic [BANK_W-1:0] ptr,
  output logic [BANK_W-1:0] gnt_idx,
  output logic              gnt_vld
);

  logic [2*N-1:0] rot;
  int             sum;

  // Bit k of rot is req[(ptr+k) mod N]; ptr is always below N.
  always_comb begin
    rot     = {req, req} >> ptr;
    sum     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld && rot[k]) begin
        gnt_vld = 1'b1;
        sum     = int'(ptr) + k;
        gnt_idx = BANK_W'((sum >= N) ? sum - N : sum);
      end
    end
  end

endmodule

// File: rtl/ul_ram_rd_ctrl_mb.sv
// Multi-bank uplink RAM read controller with read/written bank handshake.
// Define ULRD_FRAME_STAT_EN to add frame_cnt and sticky overrun outputs.
module ul_ram_rd_ctrl_mb
  import ul_rdctrl_pkg::*;
#(
  parameter int NUM_BANKS   = 2,
  parameter int ADDR_W      = 10,
  parameter int BANK_STRIDE = 512,
  parameter int FRAME_LEN   = 262,
  parameter int RAM_LAT     = 1,
  parameter int DONE_HOLD   = 6
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [NUM_BANKS-1:0] wr_state,
  output logic [NUM_BANKS-1:0] rd_state,
  input  logic                 out_ready,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic [BANK_W-1:0]    out_bank,
  output logic                 busy
`ifdef ULRD_FRAME_STAT_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic                 overrun
`endif
);

  if (FRAME_LEN > BANK_STRIDE) begin : g_chk_len
    $error("FRAME_LEN exceeds BANK_STRIDE");
  end
  if (NUM_BANKS * BANK_STRIDE > 2 ** ADDR_W) begin : g_chk_map
    $error("bank map exceeds address space");
  end

  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [15:0]       HOLD_LAST = 16'(DONE_HOLD - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

  rd_fsm_e              state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [BANK_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    base;
  logic [15:0]          hold_q, hold_d;
  logic                 rd_en_q, rd_en_d;
  logic                 fst_q, fst_d;
  logic                 lst_q, lst_d;
  logic [RAM_LAT-1:0]   vld_q, vld_d;
  logic [RAM_LAT-1:0]   pf_q, pf_d;
  logic [RAM_LAT-1:0]   pl_q, pl_d;
  logic [NUM_BANKS-1:0] rs_q, rs_d;
  logic [NUM_BANKS-1:0] wr_q;
  logic [NUM_BANKS-1:0] set_v;
  logic [NUM_BANKS-1:0] elig;
  logic [BANK_W-1:0]    gnt_idx;
  logic                 gnt_vld;
  logic                 done_ev;

  assign elig    = wr_state & ~rs_q;
  assign base    = ADDR_W'(bank_base(32'(bank_q), BANK_STRIDE));
  assign done_ev = (state_q == S_DRAIN) && pl_q[RAM_LAT-1];

  ul_rr_arbiter #(
    .N (NUM_BANKS)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    rd_en_d = 1'b0;
    fst_d   = 1'b0;
    lst_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          bank_d  = gnt_idx;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (out_ready) begin
          rd_en_d = 1'b1;
          addr_d  = base + cnt_q;
          fst_d   = (cnt_q == '0);
          lst_d   = (cnt_q == CNT_LAST);
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_ev) begin
          state_d = S_DONE;
          hold_d  = '0;
          ptr_d   = (bank_q == BANK_LAST) ? '0
                  : bank_q + BANK_W'(1);
        end
      end
      S_DONE: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else hold_d = hold_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d    = vld_q;
    pf_d     = pf_q;
    pl_d     = pl_q;
    vld_d[0] = rd_en_q;
    pf_d[0]  = fst_q;
    pl_d[0]  = lst_q;
    for (int i = 1; i < RAM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      pf_d[i]  = pf_q[i-1];
      pl_d[i]  = pl_q[i-1];
    end
  end

  // Set on frame completion beats a clear from a dropped wr_state.
  always_comb begin
    set_v = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (done_ev && (BANK_W'(b) == bank_q)) set_v[b] = 1'b1;
    end
    rs_d = (rs_q & wr_q) | set_v;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      rd_en_q <= 1'b0;
      fst_q   <= 1'b0;
      lst_q   <= 1'b0;
      vld_q   <= '0;
      pf_q    <= '0;
      pl_q    <= '0;
      rs_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      rd_en_q <= rd_en_d;
      fst_q   <= fst_d;
      lst_q   <= lst_d;
      vld_q   <= vld_d;
      pf_q    <= pf_d;
      pl_q    <= pl_d;
      rs_q    <= rs_d;
      wr_q    <= wr_state;
    end
  end

  assign rd_state  = rs_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign out_valid = vld_q[RAM_LAT-1];
  assign out_first = pf_q[RAM_LAT-1];
  assign out_last  = pl_q[RAM_LAT-1];
  assign out_bank  = bank_q;
  assign busy      = (state_q != S_IDLE);

`ifdef ULRD_FRAME_STAT_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic        ovr_q, ovr_d;

  // Refill seen before the reader's flag was cleared.
  always_comb begin
    fcnt_d = fcnt_q + 16'(done_ev);
    ovr_d  = ovr_q | (|(wr_state & ~wr_q & rs_q));
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fcnt_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      ovr_q  <= ovr_d;
    end
  end

  assign frame_cnt = fcnt_q;
  assign overrun   = ovr_q;
`endif

endmodule

// File: tb/tb_ul_ram_rd_ctrl_mb.sv
// Self-checking bench: frame-level vector table plus scoreboarded monitors.
module tb_ul_ram_rd_ctrl_mb;

  localparam int NB   = 2;
  localparam int AW   = 10;
  localparam int STR  = 512;
  localparam int FL   = 262;
  localparam int LAT  = 1;
  localparam int HOLD = 6;

  logic          clk = 1'b0;
  logic          nRst;
  logic          nRst4;
  logic [NB-1:0] wr_state;
  logic [NB-1:0] rd_state;
  logic          out_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [2:0]    out_bank;
  logic          busy;

  logic [3:0]    wr4;
  logic [3:0]    rd_state4;
  logic          rdy4;
  logic          rd_en4;
  logic [9:0]    rd_addr4;
  logic          out_valid4;
  logic          out_first4;
  logic          out_last4;
  logic [2:0]    out_bank4;
  logic          busy4;

`ifdef ULRD_FRAME_STAT_EN
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic [15:0]   frame_cnt4;
  logic          overrun4;
`endif

  always #5 clk = ~clk;

  ul_ram_rd_ctrl_mb #(
    .NUM_BANKS(NB), .ADDR_W(AW), .BANK_STRIDE(STR),
    .FRAME_LEN(FL), .RAM_LAT(LAT), .DONE_HOLD(HOLD)
  ) u_dut (
    .clk       (clk),
    .nRst      (nRst),
    .wr_state  (wr_state),
    .rd_state  (rd_state),
    .out_ready (out_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_bank  (out_bank),
    .busy      (busy)
`ifdef ULRD_FRAME_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
`endif
  );

  ul_ram_rd_ctrl_mb #(
    .NUM_BANKS(4), .ADDR_W(10), .BANK_STRIDE(256),
    .FRAME_LEN(16), .RAM_LAT(2), .DONE_HOLD(6)
  ) u_dut4 (
    .clk       (clk),
    .nRst      (nRst4),
    .wr_state  (wr4),
    .rd_state  (rd_state4),
    .out_ready (rdy4),
    .rd_en     (rd_en4),
    .rd_addr   (rd_addr4),
    .out_valid (out_valid4),
    .out_first (out_first4),
    .out_last  (out_last4),
    .out_bank  (out_bank4),
    .busy      (busy4)
`ifdef ULRD_FRAME_STAT_EN
    ,
    .frame_cnt (frame_cnt4),
    .overrun   (overrun4)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
  } word_t;

  typedef struct {
    logic [NB-1:0] wr;
    bit            bp;
    int            nfr;
    int            b0;
    int            b1;
    logic [NB-1:0] rs;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  word_t         exp_q[$];
  logic [AW-1:0] fly_q[$];
  logic [9:0]    fly4[$];
  logic          en_d1;
  logic [1:0]    h4;
  logic          rdy_s;
  int            vld_cnt  = 0;
  int            drop_cnt = 0;
  int            idx4     = 0;
  int            t_rs0    = -1;
  int            t_b1     = -1;
  vec_t          tv[3];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic push_frame(input int b);
    word_t w;
    for (int i = 0; i < FL; i++) begin
      w.addr  = AW'(b * STR + i);
      w.first = (i == 0);
      w.last  = (i == FL - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic do_reset();
    nRst      = 1'b0;
    wr_state  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.delete();
    t_rs0 = -1;
    t_b1  = -1;
    #1 nRst = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("idle_timeout", 32'(k < 50), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    do_reset();
    push_frame(v.b0);
    if (v.nfr == 2) push_frame(v.b1);
    wr_state = v.wr;
    k = 0;
    while (rd_state != v.rs && k < 3000) begin
      if (v.bp) out_ready = ((k / 3) % 2) == 0;
      @(posedge clk); #1; k++;
    end
    out_ready = 1'b1;
    check("frame_timeout", 32'(k < 3000), 1);
    wait_idle();
    check("vld_count", vld_cnt, v.nfr * FL);
    check("exp_left", exp_q.size(), 0);
    check("rd_state_set", 32'(rd_state), 32'(v.rs));
    if (v.nfr == 2) check("done_gap", t_b1 - t_rs0, HOLD + 2);
    wr_state = '0;
    @(posedge clk); #1;
    check("rd_state_hold", 32'(rd_state), 32'(v.rs));
    @(posedge clk); #1;
    check("rd_state_clr", 32'(rd_state), 0);
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_s <= out_ready;
  end

  // Main scoreboard: issued addresses meet bench-built frame words.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    word_t         w;
    if (!nRst) begin
      fly_q.delete();
      en_d1    <= 1'b0;
      vld_cnt  = 0;
      drop_cnt = 0;
    end else begin
      check("lat", 32'(out_valid), 32'(en_d1));
      en_d1 <= rd_en;
      if (rd_en) fly_q.push_back(rd_addr);
      if (out_valid) begin
        vld_cnt++;
        if (fly_q.size() == 0 || exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underrun: got word %0d want none", vld_cnt);
        end else begin
          a = fly_q.pop_front();
          w = exp_q.pop_front();
          check("addr", 32'(a), 32'(w.addr));
          check("first", 32'(out_first), 32'(w.first));
          check("last", 32'(out_last), 32'(w.last));
        end
      end
      if (rdy_s) drop_cnt = 0;
      else if (out_valid) begin
        drop_cnt++;
        check("drop_inflight", 32'(drop_cnt <= LAT), 1);
      end
      if (rd_state[0] && t_rs0 < 0) t_rs0 = cyc;
      if (rd_en && rd_addr == AW'(STR) && t_b1 < 0) t_b1 = cyc;
    end
  end

  // Four-bank monitor: order 1,2,3 at bases 256/512/768, latency 2.
  always @(negedge clk) begin
    logic [9:0] a4;
    int         off;
    if (!nRst4) begin
      fly4.delete();
      h4   <= '0;
      idx4 = 0;
    end else begin
      check("b4_lat", 32'(out_valid4), 32'(h4[1]));
      h4 <= {h4[0], rd_en4};
      if (rd_en4) fly4.push_back(rd_addr4);
      if (out_valid4) begin
        off = idx4 % 16;
        if (fly4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b4_underrun: got word %0d want none", idx4);
        end else begin
          a4 = fly4.pop_front();
          check("b4_addr", 32'(a4), (1 + idx4 / 16) * 256 + off);
          check("b4_first", 32'(out_first4), 32'(off == 0));
          check("b4_last", 32'(out_last4), 32'(off == 15));
        end
        idx4++;
      end
    end
  end

  initial begin
    int k;
    tv[0] = '{wr: 2'b01, bp: 1'b0, nfr: 1, b0: 0, b1: 0, rs: 2'b01};
    tv[1] = '{wr: 2'b11, bp: 1'b0, nfr: 2, b0: 0, b1: 1, rs: 2'b11};
    tv[2] = '{wr: 2'b01, bp: 1'b1, nfr: 1, b0: 0, b1: 0, rs: 2'b01};

    nRst = 1'b1; nRst4 = 1'b1;
    wr_state = '0; wr4 = '0;
    out_ready = 1'b1; rdy4 = 1'b1;
    #2 nRst = 1'b0; nRst4 = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_state", 32'(rd_state), 0);
    check("rst_bank", 32'(out_bank), 0);

    nRst4 = 1'b1;
    wr4   = 4'b1110;
    k = 0;
    while (rd_state4 != 4'b1110 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    check("b4_timeout", 32'(k < 1000), 1);
    k = 0;
    while (busy4 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("b4_words", idx4, 48);
    check("b4_rd_state", 32'(rd_state4), 32'hE);

    for (int i = 0; i < 3; i++) run_vec(tv[i]);

    do_reset();
    push_frame(0);
    wr_state = 2'b01;
    k = 0;
    while (!(rd_en && rd_addr == AW'(100)) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("mid_reach", 32'(k < 500), 1);
    nRst = 1'b0;
    #1;
    check("mid_rd_en", 32'(rd_en), 0);
    check("mid_rd_addr", 32'(rd_addr), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_first_last", 32'({out_first, out_last}), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_bank", 32'(out_bank), 0);
    repeat (2) @(posedge clk);
    check("mid_rd_state", 32'(rd_state), 0);
    exp_q.delete();
    push_frame(0);
    #1 nRst = 1'b1;
    k = 0;
    while (!rd_state[0] && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    check("restart_timeout", 32'(k < 1000), 1);
    wait_idle();
    check("restart_words", vld_cnt, FL);
    check("restart_left", exp_q.size(), 0);

`ifdef ULRD_FRAME_STAT_EN
    do_reset();
    check("fc_rst", 32'(frame_cnt), 0);
    check("ov_rst", 32'(overrun), 0);
    for (int f = 0; f < 3; f++) begin
      push_frame(0);
      wr_state = 2'b01;
      k = 0;
      while (!rd_state[0] && k < 1000) begin
        @(posedge clk); #1; k++;
      end
      check("stat_timeout", 32'(k < 1000), 1);
      wait_idle();
      if (f < 2) begin
        wr_state = '0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    check("frame_cnt3", 32'(frame_cnt), 3);
    check("ov_clean", 32'(overrun), 0);
    push_frame(0);
    wr_state = '0;
    @(posedge clk); #1;
    wr_state = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ov_set", 32'(overrun), 1);
    k = 0;
    while (!rd_state[0] && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    wait_idle();
    check("ov_sticky", 32'(overrun), 1);
    check("frame_cnt4", 32'(frame_cnt), 4);
    nRst = 1'b0;
    #1;
    check("ov_rst_clr", 32'(overrun), 0);
    check("fc_rst_clr", 32'(frame_cnt), 0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
